// File: rtl/divider.sv
// divider: unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   dividend     operand, sampled in LOAD
//   divisor      operand, sampled in LOAD
//   op_start     start request, honoured only in IDLE
//   op_clear     synchronous abort, highest synchronous priority
//   op_done      one-cycle pulse while in DONE
//   quotient     quotient register (shifts in result bits during ITER)
//   remainder    partial/final remainder register
//   div_by_zero  last completed operation had a zero divisor
module divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             op_start,
  input  logic             op_clear,
  output logic             op_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dv;
  logic [WIDTH:0] t, d;
  logic ge, last;
  // t keeps the remainder MSB that is shifted out, so t >= dv is exact
  assign t = {remainder, quotient[WIDTH-1]};
  assign d = t - {1'b0, dv};
  assign ge = t >= {1'b0, dv};
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // the zero-divisor decision in LOAD uses the operand being captured this cycle
  always_comb
    state_nx = op_clear ? IDLE :
               state == IDLE ? (op_start ? LOAD : IDLE) :
               state == LOAD ? (divisor == '0 ? DONE : ITER) :
               state == ITER ? (last ? DONE : ITER) : IDLE;
  always_comb op_done = state == DONE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      cnt <= '0;
      dv <= '0;
    end else if (op_clear) begin
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      cnt <= '0;
    end else if (state == LOAD) begin
      dv <= divisor;
      cnt <= '0;
      quotient <= divisor == '0 ? '1 : dividend;
      remainder <= divisor == '0 ? dividend : '0;
      div_by_zero <= divisor == '0;
    end else if (state == ITER) begin
      remainder <= ge ? d[WIDTH-1:0] : t[WIDTH-1:0];
      quotient <= {quotient[WIDTH-2:0], ge};
      cnt <= cnt + CW'(1);
    end
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed and randomized checks of divider against a reference model.
module tb_divider;
  localparam int W = 64;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic op_start = 1'b0;
  logic op_clear = 1'b0;
  logic op_done, div_by_zero;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic z;
    int lat;
  } exp_t;
  exp_t sb[$];
  divider #(.WIDTH(W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .dividend(dividend),
    .divisor(divisor),
    .op_start(op_start),
    .op_clear(op_clear),
    .op_done(op_done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // latency k counts cycles from the one in which op_start is high (k=0)
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    exp_t e;
    int k;
    e.z = b == '0;
    e.q = e.z ? '1 : a / b;
    e.r = e.z ? a : a % b;
    e.lat = e.z ? 2 : W + 2;
    sb.push_back(e);
    @(negedge clk);
    dividend = a;
    divisor = b;
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    k = 1;
    while (!op_done && k < 2 * W + 10) begin
      if (poke && k == 10) begin
        op_start = 1'b1;
        dividend = ~a;
        divisor = b + 1;
      end else op_start = 1'b0;
      @(negedge clk);
      k++;
    end
    op_start = 1'b0;
    e = sb.pop_front();
    chk("done", W'(op_done), W'(1));
    chk("latency", W'(k), W'(e.lat));
    chk("quotient", quotient, e.q);
    chk("remainder", remainder, e.r);
    chk("div_by_zero", W'(div_by_zero), W'(e.z));
    @(negedge clk);
    chk("done_pulse", W'(op_done), W'(0));
    chk("hold_q", quotient, e.q);
    chk("hold_r", remainder, e.r);
  endtask
  initial begin
    logic [W-1:0] a, b;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_q", quotient, '0);
    chk("rst_r", remainder, '0);
    chk("rst_z", W'(div_by_zero), W'(0));
    chk("rst_done", W'(op_done), W'(0));
    reset_n = 1'b1;
    run_op(64'd100, 64'd7, 1'b0);
    run_op('1, 64'd1, 1'b0);
    run_op('1, 64'h8000_0000_0000_0001, 1'b0);
    run_op(64'h1234, '0, 1'b0);
    run_op(64'd100, 64'd7, 1'b1);
    // abort at ITER cycle 30 (ITER cycle 0 is k=2)
    @(negedge clk);
    dividend = 64'd1000;
    divisor = 64'd3;
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    repeat (31) @(negedge clk);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    chk("clr_q", quotient, '0);
    chk("clr_r", remainder, '0);
    chk("clr_z", W'(div_by_zero), W'(0));
    chk("clr_done", W'(op_done), W'(0));
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (op_done) seen = 1'b1;
    end
    chk("clr_no_done", W'(seen), W'(0));
    // start together with clear must not leave IDLE
    run_op(64'd77, 64'd5, 1'b0);
    @(negedge clk);
    dividend = 64'd999;
    divisor = 64'd4;
    op_start = 1'b1;
    op_clear = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    op_clear = 1'b0;
    chk("sc_q", quotient, '0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (op_done) seen = 1'b1;
    end
    chk("sc_q_idle", quotient, '0);
    chk("sc_no_done", W'(seen), W'(0));
    // asynchronous reset mid-ITER
    @(negedge clk);
    dividend = 64'd1000;
    divisor = 64'd3;
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_q", quotient, '0);
    chk("arst_r", remainder, '0);
    chk("arst_z", W'(div_by_zero), W'(0));
    chk("arst_done", W'(op_done), W'(0));
    @(negedge clk);
    reset_n = 1'b1;
    run_op(64'd50, 64'd5, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(63, 0);
      if (b == '0) b = 64'd1;
      run_op(a, b, 1'b0);
      chk("rnd_identity", quotient * b + remainder, a);
      chk("rnd_rem_lt", W'(remainder < b), W'(1));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
